cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Miss-service controller for one cache's memory-side port. It accepts a miss from the cache tag/data logic and, if the victim line is dirty, issues the writeback: one write request plus four data beats. It then issues the line refill read and steers the four response beats into the cache data array. It sits between a cache's lookup logic and the I/D memory arbiter. It owns the mem_req / mem_req_data handshakes for that cache.

## Interface
- MEM_ADDR_BITS, 28, line address width (matches `MEM_ADDR_BITS)
- MEM_DATA_BITS, 128, memory beat width (matches `MEM_DATA_BITS)
- BEATS, 4, beats per cache line; fixed at 4 (offset is 2 bits)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- miss_valid  in  1  cache requests miss service
- miss_ready  out  1  controller idle, miss accepted this cycle if miss_valid
- miss_addr  in  MEM_ADDR_BITS  line address to refill
- victim_dirty  in  1  victim line must be written back
- victim_addr  in  MEM_ADDR_BITS  victim line address
- victim_data  in  BEATS*MEM_DATA_BITS  victim line, beat 0 in LSBs
- mem_req_valid  out  1  command valid
- mem_req_ready  in  1  command accepted
- mem_req_rw  out  1  1 = write, 0 = read
- mem_req_addr  out  MEM_ADDR_BITS  command line address
- mem_req_data_valid  out  1  write beat valid
- mem_req_data_ready  in  1  write beat accepted
- mem_req_data_bits  out  MEM_DATA_BITS  write beat
- mem_req_data_mask  out  MEM_DATA_BITS/8  byte mask, all ones during writeback
- mem_req_data_offset  out  2  beat index of current write beat
- mem_resp_valid  in  1  read beat valid (already tag-routed to this cache)
- mem_resp_data  in  MEM_DATA_BITS  read beat
- refill_we  out  1  write refill beat into data array
- refill_idx  out  2  beat index of refill_data
- refill_data  out  MEM_DATA_BITS  refill beat (mem_resp_data registered-free passthrough)
- done  out  1  one-cycle pulse: line installed, cache may set tag/valid and clear dirty

## Operation
- States: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_RESP, DONE. Two-bit beat counter `beat`.
- IDLE: miss_ready=1. On miss_valid, latch miss_addr, victim_addr, victim_data and victim_dirty. Clear beat. Go to WB_REQ if dirty, else RD_REQ.
- WB_REQ: mem_req_valid=1, rw=1, addr=latched victim_addr. On mem_req_ready, go to WB_DATA.
- WB_DATA: mem_req_data_valid=1, offset=beat, bits=latched victim beat[beat], mask all ones. Each data handshake increments beat. The handshake with beat==3 clears beat and goes to RD_REQ.
- RD_REQ: mem_req_valid=1, rw=0, addr=latched miss_addr. On mem_req_ready, go to RD_RESP.
- RD_RESP: each mem_resp_valid drives refill_we=1, refill_idx=beat, refill_data=mem_resp_data, then increments beat. The beat==3 response goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outside the active state, every valid/we output is 0; mem_req_rw=0 and mem_req_data_mask=0.
- mem_resp_valid outside RD_RESP is ignored and produces no refill_we.

## Timing
- Reset: state=IDLE, beat=0, all latched registers 0. miss_ready=1. mem_req_valid, mem_req_data_valid, refill_we and done are 0.
- Reset mid-operation aborts any transaction immediately; no further beats are driven. The memory side is reset together with the controller.
- Valid outputs depend only on state, never combinationally on ready.
- Once asserted, mem_req_valid and its addr/rw are held stable until ready. The same holds for mem_req_data_valid and its bits/offset.
- Clean miss with ready always high and first response N cycles after the read command: accept at T0, RD_REQ at T1, RD_RESP from T2, beats at T2+N..T2+N+3, done at T3+N+3.
- Dirty miss adds at least 1 (WB_REQ) + 4 (WB_DATA) cycles.
- Back-to-back: a new miss can be accepted the cycle after DONE.
- Back-pressure on any handshake simply holds state; there is no timeout.

## Structure
- Shared package `cache_miss_pkg`: the state enum typedef and the BEATS / beat-index width constants. Address and data widths come from the existing `MEM_*` defines.
- One sub-module: `beat_counter`, a 2-bit counter with clear, increment and last (==3) outputs. It is shared by WB_DATA and RD_RESP.

## Test plan
- Clean miss, addr 0x0000123, ready high, responses 0xA0..0xA3 after 3 cycles -> exactly one read command, refill_idx 0..3 carry 0xA0..0xA3 in order, done once, no write activity.
- Dirty miss, victim 0x0000456, data beats 0x10..0x13, miss 0x0000789 -> write command at 0x456, data beats 0x10..0x13 at offsets 0..3 with mask all ones, then read command at 0x789, then refill and done.
- Random mem_req_ready / mem_req_data_ready stalls -> valid/addr/bits held stable while stalled, beat order preserved, no beat dropped or duplicated.
- Spurious mem_resp_valid during IDLE/WB_REQ/RD_REQ -> no refill_we, beat stays 0.
- Reset asserted in WB_DATA after beat 1 -> next cycle IDLE, miss_ready=1, all valids 0; the next dirty miss restarts at offset 0.
- Two misses back-to-back -> second accepted the cycle after done, no overlap between the two transactions' commands.

Source files
------------

// File: rtl/cache_miss_pkg.sv
// Shared types and constants for the cache miss-service controller.
// Address and data widths fall back to the memory-system defaults when not defined globally.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

package cache_miss_pkg;

    localparam int BEATS         = 4;
    localparam int BEAT_IDX_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_WB_DATA = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    function automatic logic is_last_beat(input logic [BEAT_IDX_BITS-1:0] idx);
        return idx == BEAT_IDX_BITS'(BEATS - 1);
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_beat_counter.sv
// Two-bit beat index shared by the writeback data phase and the refill response phase.
module beat_counter
    import cache_miss_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     inc,
    output logic [BEAT_IDX_BITS-1:0] value,
    output logic                     last
);

    // Beat index register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= value + BEAT_IDX_BITS'(1);
        end else begin
            value <= value;
        end
    end

    assign last = is_last_beat(value);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss-service controller: optional dirty-victim writeback, then a four-beat line refill.
// All valid/we outputs decode from state only, so they never depend combinationally on ready.
module cache_miss_ctrl
    import cache_miss_pkg::*;
#(
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS,
    parameter int MEM_DATA_BITS = `MEM_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [MEM_ADDR_BITS-1:0]     miss_addr,
    input  logic                         victim_dirty,
    input  logic [MEM_ADDR_BITS-1:0]     victim_addr,
    input  logic [BEATS*MEM_DATA_BITS-1:0] victim_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]     mem_req_addr,
    output logic                         mem_req_data_valid,
    input  logic                         mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]     mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
    output logic [BEAT_IDX_BITS-1:0]     mem_req_data_offset,
    input  logic                         mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]     mem_resp_data,
    output logic                         refill_we,
    output logic [BEAT_IDX_BITS-1:0]     refill_idx,
    output logic [MEM_DATA_BITS-1:0]     refill_data,
    output logic                         done
);

    state_e                         state_r;
    state_e                         state_s;
    logic [MEM_ADDR_BITS-1:0]       miss_addr_r;
    logic [MEM_ADDR_BITS-1:0]       victim_addr_r;
    logic [BEATS*MEM_DATA_BITS-1:0] victim_data_r;
    logic                           accept_s;
    logic                           beat_clr_s;
    logic                           beat_inc_s;
    logic [BEAT_IDX_BITS-1:0]       beat_s;
    logic                           beat_last_s;

    beat_counter u_beat (
        .clk   (clk),
        .reset (reset),
        .clr   (beat_clr_s),
        .inc   (beat_inc_s),
        .value (beat_s),
        .last  (beat_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Miss descriptor capture at acceptance; held for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_addr_r   <= '0;
            victim_addr_r <= '0;
            victim_data_r <= '0;
        end else if (accept_s) begin
            miss_addr_r   <= miss_addr;
            victim_addr_r <= victim_addr;
            victim_data_r <= victim_data;
        end else begin
            miss_addr_r   <= miss_addr_r;
            victim_addr_r <= victim_addr_r;
            victim_data_r <= victim_data_r;
        end
    end

    // Next-state and beat-counter control.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        beat_clr_s = 1'b0;
        beat_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (miss_valid) begin
                    accept_s   = 1'b1;
                    beat_clr_s = 1'b1;
                    state_s    = victim_dirty ? ST_WB_REQ : ST_RD_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB_REQ: begin
                if (mem_req_ready) state_s = ST_WB_DATA;
                else               state_s = ST_WB_REQ;
            end
            ST_WB_DATA: begin
                if (mem_req_data_ready && beat_last_s) begin
                    beat_clr_s = 1'b1;
                    state_s    = ST_RD_REQ;
                end else if (mem_req_data_ready) begin
                    beat_inc_s = 1'b1;
                end else begin
                    state_s = ST_WB_DATA;
                end
            end
            ST_RD_REQ: begin
                if (mem_req_ready) state_s = ST_RD_RESP;
                else               state_s = ST_RD_REQ;
            end
            ST_RD_RESP: begin
                if (mem_resp_valid && beat_last_s) begin
                    beat_clr_s = 1'b1;
                    state_s    = ST_DONE;
                end else if (mem_resp_valid) begin
                    beat_inc_s = 1'b1;
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode; inactive outputs are forced to zero.
    always_comb begin
        miss_ready          = 1'b0;
        mem_req_valid       = 1'b0;
        mem_req_rw          = 1'b0;
        mem_req_addr        = '0;
        mem_req_data_valid  = 1'b0;
        mem_req_data_bits   = '0;
        mem_req_data_mask   = '0;
        mem_req_data_offset = '0;
        refill_we           = 1'b0;
        refill_idx          = '0;
        done                = 1'b0;
        case (state_r)
            ST_IDLE: miss_ready = 1'b1;
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = victim_addr_r;
            end
            ST_WB_DATA: begin
                mem_req_data_valid  = 1'b1;
                mem_req_data_offset = beat_s;
                mem_req_data_bits   = victim_data_r[32'(beat_s) * MEM_DATA_BITS +: MEM_DATA_BITS];
                mem_req_data_mask   = {(MEM_DATA_BITS/8){1'b1}};
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = miss_addr_r;
            end
            ST_RD_RESP: begin
                refill_we  = mem_resp_valid;
                refill_idx = beat_s;
            end
            ST_DONE: done = 1'b1;
            default: miss_ready = 1'b0;
        endcase
    end

    assign refill_data = mem_resp_data;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench: stimulus pushes expected commands/beats/refills, a monitor pops and compares.
module tb_cache_miss_ctrl;
    localparam int AW = 28;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            miss_valid = 1'b0;
    logic            miss_ready;
    logic [AW-1:0]   miss_addr = '0;
    logic            victim_dirty = 1'b0;
    logic [AW-1:0]   victim_addr = '0;
    logic [4*DW-1:0] victim_data = '0;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b1;
    logic            mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_data_valid;
    logic            mem_req_data_ready = 1'b1;
    logic [DW-1:0]   mem_req_data_bits;
    logic [DW/8-1:0] mem_req_data_mask;
    logic [1:0]      mem_req_data_offset;
    logic            mem_resp_valid = 1'b0;
    logic [DW-1:0]   mem_resp_data = '0;
    logic            refill_we;
    logic [1:0]      refill_idx;
    logic [DW-1:0]   refill_data;
    logic            done;

    cache_miss_ctrl dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_data(victim_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_req_data_offset(mem_req_data_offset), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .refill_we(refill_we), .refill_idx(refill_idx),
        .refill_data(refill_data), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [AW:0]         cq[$];
    logic [2+DW+DW/8-1:0] wq[$];
    logic [2+DW-1:0]     rq[$];
    logic [DW-1:0]       rbq[$];
    int  dq = 0;
    int  cyc = 0;
    int  accept_cyc = 0;
    int  done_cyc = 0;
    int  wb_cnt = 0;
    bit  ready_rand = 1'b0;
    bit  spur = 1'b0;
    int  resp_delay = 3;
    bit  resp_active = 1'b0;
    int  resp_cnt = 0;
    int  resp_idx = 0;
    logic [DW-1:0] resp_cur = '0;
    logic          p_rv = 1'b0, p_rr = 1'b0, p_dv = 1'b0, p_dr = 1'b0;
    logic [AW:0]   p_cmd = '0;
    logic [DW+1:0] p_dat = '0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected expected=none", name);
    endtask

    // Driver (posedge+1) and monitor/scoreboard (negedge) in one process.
    initial begin
        logic [AW:0]          ec;
        logic [2+DW+DW/8-1:0] ew;
        logic [2+DW-1:0]      er;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_req_ready      = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_req_data_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_active && resp_cnt > 0) begin
                resp_cnt--;
                mem_resp_valid = 1'b0;
            end else if (resp_active) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = resp_cur + DW'(resp_idx);
                resp_idx++;
                if (resp_idx == 4) resp_active = 1'b0;
            end else begin
                mem_resp_valid = spur;
                mem_resp_data  = DW'(8'hEE);
            end
            @(negedge clk);
            if (reset) begin
                resp_active = 1'b0;
                p_rv = 1'b0;
                p_dv = 1'b0;
            end else begin
                if (p_rv && !p_rr) chk("cmd_hold", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, p_cmd});
                if (p_dv && !p_dr) chk("data_hold", {mem_req_data_valid, mem_req_data_offset, mem_req_data_bits}, {1'b1, p_dat});
                p_rv = mem_req_valid; p_rr = mem_req_ready; p_cmd = {mem_req_rw, mem_req_addr};
                p_dv = mem_req_data_valid; p_dr = mem_req_data_ready;
                p_dat = {mem_req_data_offset, mem_req_data_bits};
                if (miss_valid && miss_ready) accept_cyc = cyc;
                if (mem_req_valid && mem_req_ready) begin
                    if (cq.size() == 0) unexp("cmd");
                    else begin
                        ec = cq.pop_front();
                        chk("cmd", {mem_req_rw, mem_req_addr}, ec);
                    end
                    if (!mem_req_rw) begin
                        spur = 1'b0;
                        resp_active = 1'b1;
                        resp_cnt = resp_delay;
                        resp_idx = 0;
                        resp_cur = (rbq.size() != 0) ? rbq.pop_front() : '0;
                    end
                end
                if (mem_req_data_valid && mem_req_data_ready) begin
                    wb_cnt++;
                    if (wq.size() == 0) unexp("wbeat");
                    else begin
                        ew = wq.pop_front();
                        chk("wbeat", {mem_req_data_offset, mem_req_data_bits, mem_req_data_mask}, ew);
                    end
                end
                if (refill_we) begin
                    if (rq.size() == 0) unexp("refill");
                    else begin
                        er = rq.pop_front();
                        chk("refill", {refill_idx, refill_data}, er);
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    if (dq == 0) unexp("done");
                    else dq--;
                end
            end
        end
    end

    task automatic issue_miss(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] va,
                              input logic [4*DW-1:0] vd, input logic [DW-1:0] rbase);
        bit ok = 1'b0;
        if (dirty) begin
            cq.push_back({1'b1, va});
            for (int i = 0; i < 4; i++)
                wq.push_back({2'(i), vd[i*DW +: DW], {(DW/8){1'b1}}});
        end
        cq.push_back({1'b0, ma});
        for (int i = 0; i < 4; i++) rq.push_back({2'(i), rbase + DW'(i)});
        rbq.push_back(rbase);
        dq++;
        miss_valid = 1'b1; miss_addr = ma; victim_dirty = dirty; victim_addr = va; victim_data = vd;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = miss_ready;
        end
        if (!ok) unexp("accept_timeout");
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cq.size() == 0 && wq.size() == 0 && rq.size() == 0 && dq == 0) break;
        end
        chk({tag, "_cmd_left"}, 200'(cq.size()), 200'd0);
        chk({tag, "_wbeat_left"}, 200'(wq.size()), 200'd0);
        chk({tag, "_refill_left"}, 200'(rq.size()), 200'd0);
        chk({tag, "_done_left"}, 200'(dq), 200'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_idle"}, {miss_ready, mem_req_valid, mem_req_data_valid, refill_we, done,
                             mem_req_rw, mem_req_data_mask}, {5'b10000, 1'b0, 16'h0000});
    endtask

    initial begin
        logic [4*DW-1:0] vd1, vd2;
        int first_done;
        vd1 = {DW'(8'h13), DW'(8'h12), DW'(8'h11), DW'(8'h10)};
        vd2 = {DW'(32'hDDDD0003), DW'(32'hDDDD0002), DW'(32'hDDDD0001), DW'(32'hDDDD0000)};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        idle_check("reset");
        @(posedge clk); #1;

        // Clean miss, ready high, response after 3 cycles.
        issue_miss(28'h0000123, 1'b0, 28'h0, '0, DW'(8'hA0));
        drain("clean");
        chk("clean_latency", 200'(done_cyc - accept_cyc), 200'd9);

        // Dirty miss with writeback.
        issue_miss(28'h0000789, 1'b1, 28'h0000456, vd1, DW'(8'hC0));
        drain("dirty");

        // Random back-pressure on both request channels.
        ready_rand = 1'b1;
        issue_miss(28'h0ABCDEF, 1'b1, 28'h0FEDCBA, vd2, DW'(8'h50));
        drain("stall");

        // Spurious responses while idle and before the read command.
        spur = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue_miss(28'h0000321, 1'b1, 28'h0000654, vd1, DW'(8'h70));
        drain("spur");
        ready_rand = 1'b0;

        // Reset in WB_DATA after beat 1 is accepted.
        wb_cnt = 0;
        issue_miss(28'h0000111, 1'b1, 28'h0000222, vd2, DW'(8'h90));
        for (int k = 0; k < 100 && wb_cnt < 2; k++) @(negedge clk);
        chk("rst_wb_progress", 200'(wb_cnt), 200'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cq.delete(); wq.delete(); rq.delete(); rbq.delete(); dq = 0;
        @(negedge clk);
        idle_check("midreset");
        @(posedge clk); #1;
        issue_miss(28'h0000333, 1'b1, 28'h0000444, vd1, DW'(8'hB0));
        drain("restart");

        // Back-to-back misses.
        issue_miss(28'h0000AAA, 1'b0, 28'h0, '0, DW'(8'h20));
        first_done = done_cyc;
        issue_miss(28'h0000BBB, 1'b1, 28'h0000CCC, vd2, DW'(8'h30));
        chk("b2b_accept", 200'(accept_cyc), 200'(done_cyc + 1));
        chk("b2b_done_moved", 200'(done_cyc != first_done), 200'd1);
        drain("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
